// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select/enable lines of an 8-to-1 mux; each grant lasts DWELL unpaused cycles.
// Optional early release of a grant whose requester drops is enabled by defining MUX_SCHED_EARLY_RELEASE_EN.
module mux8_rr_sched #(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       pause,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       en,
  output logic [7:0] grant,
  output logic       busy,
  output logic       last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [3:0]       pick;
  logic             last_w;

  // Returns {found, index}; scans ptr+1 upward and wraps, so ptr itself is visited last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 8; i >= 1; i--) begin
      idx = p + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX_SCHED_EARLY_RELEASE_EN
  assign last_w = (state_q == GRANT) & ~pause & ((cnt_q == '0) | ~req[ptr_q]);
`else
  assign last_w = (state_q == GRANT) & ~pause & (cnt_q == '0);
`endif

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (!pause && pick[3]) begin
          state_d = GRANT;
          sel_d   = pick[2:0];
          grant_d = 8'h01 << pick[2:0];
          ptr_d   = pick[2:0];
          cnt_d   = RELOAD;
          en_d    = 1'b1;
        end
      end
      GRANT: begin
        if (pause) begin
          en_d = 1'b0;
        end else if (last_w) begin
          // Final dwell cycle: hand over without a bubble, or fall back to idle.
          if (pick[3]) begin
            sel_d   = pick[2:0];
            grant_d = 8'h01 << pick[2:0];
            ptr_d   = pick[2:0];
            cnt_d   = RELOAD;
            en_d    = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = 3'd0;
            grant_d = 8'h00;
            cnt_d   = '0;
            en_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      grant_q <= 8'h00;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign {s2, s1, s0} = sel_q;
  assign en    = en_q;
  assign grant = grant_q;
  assign busy  = (state_q == GRANT);
  assign last  = last_w;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched (DWELL=4): reset, round-robin order, wrap, sole requester, pause, reset mid-grant, release.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       pause;
  logic       s0, s1, s2, en, busy, last;
  logic [7:0] grant;

  int checks   = 0;
  int failures = 0;

  mux8_rr_sched #(.DWELL(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .pause (pause),
    .s0    (s0),
    .s1    (s1),
    .s2    (s2),
    .en    (en),
    .grant (grant),
    .busy  (busy),
    .last  (last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected state: b=busy, e=en, idx=granted source, l=last.
  task automatic st(input string tag, input bit b, input bit e, input int idx, input bit l);
    logic [7:0] g;
    logic [2:0] s;
    g = b ? (8'h01 << idx) : 8'h00;
    s = b ? 3'(idx) : 3'd0;
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"}, 32'({s2, s1, s0}), 32'(s));
    chk({tag, ".en"}, 32'(en), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".last"}, 32'(last), 32'(l));
  endtask

  int seq3[3] = '{7, 0, 7};

  initial begin
    rst = 1'b1; req = 8'h00; pause = 1'b0;
    tick(); tick();
    st("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    st("idle_noreq", 0, 0, 0, 0);

    // First grant: one cycle latency, source 0.
    req = 8'h01;
    tick();
    st("first", 1, 1, 0, 0);

    // All sources requesting: 0..7 then 0, four cycles each, no gaps.
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (n == 8 && k == 3) req = 8'h81;
        #0;
        st($sformatf("rr%0d_%0d", n, k), 1, 1, n % 8, k == 3);
        tick();
      end
    end

    // Wrap between sources 7 and 0.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (n == 2 && k == 3) req = 8'h20;
        st($sformatf("wrap%0d_%0d", n, k), 1, 1, seq3[n], k == 3);
        tick();
      end
    end

    // Sole requester is re-granted continuously.
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (n == 2 && k == 3) req = 8'h00;
        st($sformatf("sole%0d_%0d", n, k), 1, 1, 5, k == 3);
        tick();
      end
    end
    st("idle_after_sole", 0, 0, 0, 0);

    // Pause for 3 cycles starting after the second dwell cycle of source 2.
    req = 8'h04;
    tick();
    st("pz_a", 1, 1, 2, 0);
    tick();
    st("pz_b", 1, 1, 2, 0);
    tick();
    pause = 1'b1; #1;
    st("pz_c", 1, 1, 2, 0);
    tick();
    st("pz_d", 1, 0, 2, 0);
    tick();
    st("pz_e", 1, 0, 2, 0);
    tick();
    pause = 1'b0; #1;
    st("pz_f", 1, 0, 2, 0);
    tick();
    pause = 1'b1; #1;
    st("pz_g_masked", 1, 1, 2, 0);
    pause = 1'b0; req = 8'h00; #1;
    st("pz_g", 1, 1, 2, 1);
    tick();
    st("pz_idle", 0, 0, 0, 0);

    // Reset during a grant of source 6; ptr returns to 7 so source 0 wins first.
    req = 8'h40;
    tick();
    st("rm_g6", 1, 1, 6, 0);
    tick();
    rst = 1'b1; req = 8'h41;
    tick();
    st("rm_reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      st($sformatf("rm_g0_%0d", k), 1, 1, 0, k == 3);
      tick();
    end
    st("rm_g6_next", 1, 1, 6, 0);

    // Requester of source 3 drops after one cycle while source 4 requests.
    rst = 1'b1; req = 8'h00;
    tick();
    rst = 1'b0;
    req = 8'h08;
    tick();
    st("er_g3", 1, 1, 3, 0);
    tick();
    req = 8'h10; #1;
`ifdef MUX_SCHED_EARLY_RELEASE_EN
    st("er_release", 1, 1, 3, 1);
    tick();
    st("er_g4", 1, 1, 4, 0);
`else
    for (int k = 1; k < 4; k++) begin
      st($sformatf("er_hold%0d", k), 1, 1, 3, k == 3);
      tick();
    end
    st("er_g4", 1, 1, 4, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
